booth_mul_arbiter: RTL
======================

// Module: booth_mul_arbiter
// PURPOSE
//   Shares one combinational signed 32x32 Booth multiplier (boothmultiplier32) between NREQ
//   requesters. Round-robin arbitration, valid/ready handshakes on every requester and
//   on the single response port. Two-stage registered pipeline; the response carries the winner's ID.
//   Sits between datapath clients (MAC/ALU lanes) and the shared multiplier.
// PARAMETERS
//   NREQ    4   number of requesters, 2..8
//   IDW     2   response ID width, = $clog2(NREQ)
// PORTS
//   clk          in   1          single clock; all state updates on rising edge
//   rst          in   1          synchronous, active-high reset
//   req_valid    in   NREQ       requester i presents operands
//   req_ready    out  NREQ       one-hot or zero; bit i high = requester i accepted this cycle
//   req_m        in   32*NREQ    multiplicand of requester i at [32*i +: 32], two's complement
//   req_q        in   32*NREQ    multiplier of requester i at [32*i +: 32], two's complement
//   rsp_valid    out  1          result available
//   rsp_ready    in   1          consumer accepts result
//   rsp_result   out  64         signed product M*Q
//   rsp_id       out  IDW        index of requester that issued the operands
// BEHAVIOUR
//   - Reset: rsp_valid=0, rsp_result=0, rsp_id=0, s1_valid=0, rr_ptr=0. req_ready=0 while rst=1.
//   - Stage S1 (operand reg: m, q, id, s1_valid) drives the multiplier. Qm1 is tied 0.
//     Stage S2 (rsp_* regs) captures the product.
//   - Stall chain: s2_free = !rsp_valid | rsp_ready; s1_free = !s1_valid | s2_free.
//   - Arbitration, combinational: if s1_free, grant the first i with req_valid[i] set,
//     scanning rr_ptr, rr_ptr+1, ... mod NREQ. req_ready = onehot(grant); else all zero.
//   - On grant g: S1 <= {req_m[g], req_q[g], g, 1}; rr_ptr <= (g+1) mod NREQ.
//     With no grant, rr_ptr holds.
//   - If s1_free and no grant: s1_valid <= 0.
//   - If s1_valid & s2_free: rsp_result <= product; rsp_id <= S1.id; rsp_valid <= 1.
//   - Else if rsp_ready: rsp_valid <= 0.
//   - Latency: accept at edge N -> rsp_valid high after edge N+1, i.e. 2 cycles from the
//     req_valid&req_ready cycle.
//   - Throughput: 1 result/cycle when rsp_ready=1 continuously.
//   - Backpressure: rsp_valid=1 & rsp_ready=0 holds rsp_* stable. S1 then fills and holds,
//     and req_ready goes all-zero. No data loss and no duplication.
//   - req_ready is a function of state and req_valid only, never of req_m/req_q.
//   - A requester may drop req_valid without handshake. Operands are sampled only on the
//     ready cycle.
//   - Simultaneous rsp consume and S1 advance in the same cycle is legal: full pipeline
//     keeps streaming.
//   - Reset mid-operation: in-flight S1/S2 contents are discarded and no response is issued.
//     The first grant after reset goes to the lowest valid index.
//   - Arithmetic: result = sign-extended M * sign-extended Q, 64-bit exact.
//     Includes -2^31 * -2^31 = 0x4000_0000_0000_0000.
// STRUCTURE
//   - Package booth_arb_pkg: NREQ/IDW defaults, localparams OPW=32, RESW=64,
//     typedef of the S1 operand record {m, q, id}.
//   - Sub-module rr_arbiter (req, ptr -> onehot grant, grant index). Purely combinational;
//     rr_ptr register lives in the top.
//   - Top instantiates one boothmultiplier32 on the S1 outputs.
// TESTING
//   - Single: req_valid=0001, M=-3, Q=7 -> accepted cycle 0; rsp_valid cycle 2,
//     rsp_result=0xFFFF_FFFF_FFFF_FFEB, rsp_id=0.
//   - Fairness: all 4 requesters valid continuously, rsp_ready=1
//     -> grant order 0,1,2,3,0,1...; one rsp per cycle; ids match that order.
//   - Backpressure: 4 streams, rsp_ready=0 for 5 cycles -> exactly 2 accepts then
//     req_ready=0. rsp_* stable. On release, results drain in order with none lost.
//   - Corners: (0x8000_0000, 0x8000_0000) -> 0x4000_0000_0000_0000;
//     (0x7FFF_FFFF, -1) -> 0xFFFF_FFFF_8000_0001; (x, 0) -> 0.
//   - Reset mid-flight: rst during S1/S2 occupancy -> rsp_valid=0 next cycle.
//     The response is never emitted, and the next grant goes to the lowest valid index.
//   - Random: constrained-random operands, valid and ready -> scoreboard products against
//     a signed 64-bit model; per-id order is preserved.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// rtl/booth_arb_pkg.sv - shared constants, S1 operand record and pointer helper for booth_mul_arbiter
package booth_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;
    localparam int OPW      = 32;
    localparam int RESW     = 64;

    // Widest id needed for the largest supported requester count (8)
    localparam int IDW_MAX  = 3;

    // Operand record held in stage S1 while the multiplier evaluates it
    typedef struct packed {
        logic [OPW-1:0]     m;
        logic [OPW-1:0]     q;
        logic [IDW_MAX-1:0] id;
    } s1_rec_t;

    // Round-robin successor of index g among n requesters
    function automatic int rr_next(input int g, input int n);
        return (g + 1 == n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/boothmultiplier32.sv
// rtl/boothmultiplier32.sv - combinational radix-2 Booth signed 32x32 -> 64 multiplier
module boothmultiplier32
    import booth_arb_pkg::*;
(
    input  logic [OPW-1:0]  m,
    input  logic [OPW-1:0]  q,
    input  logic            qm1,
    output logic [RESW-1:0] product
);

    logic [RESW-1:0] m_ext;
    logic [RESW-1:0] partial;
    logic [RESW-1:0] acc;
    logic [OPW:0]    qx;

    // Recode each adjacent multiplier bit pair: 10 subtracts, 01 adds the shifted multiplicand.
    // The top pair carries the sign weight, so the 64-bit modular sum is the exact signed product.
    always_comb begin
        m_ext   = {{(RESW-OPW){m[OPW-1]}}, m};
        qx      = {q, qm1};
        acc     = '0;
        partial = '0;
        for (int i = 0; i < OPW; i++) begin
            partial = m_ext << i;
            case ({qx[i+1], qx[i]})
                2'b10:   acc = acc - partial;
                2'b01:   acc = acc + partial;
                default: acc = acc;
            endcase
        end
    end

    assign product = acc;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting its scan at ptr
module rr_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    int idx;

    // Scan ptr, ptr+1, ... modulo NREQ and pick the first requester that is asking
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin sharing of one Booth multiplier over a two-stage pipeline
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_m,
    input  logic [OPW*NREQ-1:0] req_q,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESW-1:0]     rsp_result,
    output logic [IDW-1:0]      rsp_id
);

    logic            s1_valid;
    s1_rec_t         s1;
    s1_rec_t         s1_in;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_next;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic            s2_free;
    logic            s1_free;
    logic [RESW-1:0] product;
    logic            unused_id_bits;

    // A stage may take new data when it is empty or its content leaves this cycle
    assign s2_free = !rsp_valid || rsp_ready;
    assign s1_free = !s1_valid || s2_free;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Ready depends only on pipeline state and req_valid; nothing is offered during reset
    always_comb begin
        req_ready = '0;
        if (!rst && s1_free) begin
            req_ready = grant;
        end
    end

    // Gather the winner's operands into the S1 record format
    always_comb begin
        s1_in.m  = req_m[int'(grant_idx)*OPW +: OPW];
        s1_in.q  = req_q[int'(grant_idx)*OPW +: OPW];
        s1_in.id = IDW_MAX'(grant_idx);
    end

    assign ptr_next = IDW'(rr_next(int'(grant_idx), NREQ));

    // Upper id bits are always zero when IDW is narrower than IDW_MAX
    assign unused_id_bits = ^s1.id;

    boothmultiplier32 u_mul (
        .m       (s1.m),
        .q       (s1.q),
        .qm1     (1'b0),
        .product (product)
    );

    // Advance S1 on a grant and S2 whenever S1 holds data that can move forward
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1         <= '0;
            rr_ptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
        end else begin
            if (s1_free) begin
                if (grant_valid) begin
                    s1       <= s1_in;
                    s1_valid <= 1'b1;
                    rr_ptr   <= ptr_next;
                end else begin
                    s1_valid <= 1'b0;
                end
            end
            if (s1_valid && s2_free) begin
                rsp_result <= product;
                rsp_id     <= s1.id[IDW-1:0];
                rsp_valid  <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule
